// File: rtl/mdu_pkg.sv
// Shared definitions for the MIPS54 multiply/divide unit: op encodings,
// FSM state type and iteration count.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int MDU_ITER  = MDU_WIDTH;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL   = 3'd1,
    DIV   = 3'd2,
    FIXUP = 3'd3,
    DONE  = 3'd4
  } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration of the MDU datapath (combinational): shift-add
// multiply or restoring divide on the {acc_hi, acc_lo} accumulator pair.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic             div_mode,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] acc_hi_nxt,
  output logic [WIDTH-1:0] acc_lo_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shl;
  logic [WIDTH:0] diff;

  always_comb begin
    sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    shl  = {acc_hi, acc_lo[WIDTH-1]};
    diff = shl - {1'b0, opnd};
    if (div_mode) begin
      // partial remainder stays below the divisor, so bit WIDTH of diff is the borrow
      if (!diff[WIDTH]) begin
        acc_hi_nxt = diff[WIDTH-1:0];
        acc_lo_nxt = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        acc_hi_nxt = shl[WIDTH-1:0];
        acc_lo_nxt = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_hi_nxt = sum[WIDTH:1];
      acc_lo_nxt = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding HI/LO. Define MDU_FAST_MUL_EN
// for a single-cycle multiply; divide always iterates.
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO writes accepted
// MUL   | shift-add multiply step, one per cycle, WIDTH cycles
// DIV   | restoring divide step, one per cycle, WIDTH cycles
// FIXUP | sign correction, HI/LO written at end of cycle
// DONE  | done pulse; behaves like IDLE for start and writes
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opr1,
  input  logic [WIDTH-1:0] opr2,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             neg_q, neg_d, rem_neg_q, rem_neg_d, is_div_q, is_div_d;

  logic             div_mode;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic             signed_op, op_div, sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [2*WIDTH-1:0] prod_fix;

`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`endif

  assign div_mode = (state_q == DIV);

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .div_mode   (div_mode),
    .acc_hi     (acc_hi_q),
    .acc_lo     (acc_lo_q),
    .opnd       (opnd_q),
    .acc_hi_nxt (step_hi),
    .acc_lo_nxt (step_lo)
  );

  always_comb begin
    signed_op = (op == MDU_MULT) || (op == MDU_DIV);
    op_div    = (op == MDU_DIV) || (op == MDU_DIVU);
    sign_a    = signed_op & opr1[WIDTH-1];
    sign_b    = signed_op & opr2[WIDTH-1];
    mag_a     = sign_a ? -opr1 : opr1;
    mag_b     = sign_b ? -opr2 : opr2;
    prod_fix  = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    is_div_d  = is_div_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          cnt_d     = '0;
          opnd_d    = op_div ? mag_b : mag_a;
          acc_lo_d  = op_div ? mag_a : mag_b;
          acc_hi_d  = '0;
          is_div_d  = op_div;
          rem_neg_d = op_div & sign_a;
          // divide by zero keeps the all-ones quotient unnegated
          neg_d     = (sign_a ^ sign_b) & ~(op_div & (opr2 == '0));
          state_d   = op_div ? DIV : MUL;
`ifdef MDU_FAST_MUL_EN
          if (!op_div) begin
            {acc_hi_d, acc_lo_d} = fast_prod;
            state_d = FIXUP;
          end
`endif
        end else begin
          if (wr_hi) hi_d = wdata;
          if (wr_lo) lo_d = wdata;
          state_d = IDLE;
        end
      end
      MUL, DIV: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIXUP;
      end
      FIXUP: begin
        if (is_div_q) begin
          lo_d = neg_q ? -acc_lo_q : acc_lo_q;
          hi_d = rem_neg_q ? -acc_hi_q : acc_hi_q;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        cnt_d   = '0;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      is_div_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      is_div_q  <= is_div_d;
    end
  end

  assign busy = (state_q == MUL) || (state_q == DIV) || (state_q == FIXUP);
  assign done = (state_q == DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed and random ops against an
// arithmetic reference model; honours MDU_FAST_MUL_EN for multiply latency.
module tb_mul_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, wr_hi, wr_lo, busy, done;
  logic [1:0]   op;
  logic [W-1:0] opr1, opr2, wdata, hi, lo;
  int n_cmp = 0;
  int n_err = 0;

  logic [1:0]   d_op [0:8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b10, 2'b00, 2'b10};
  logic [W-1:0] d_a  [0:8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7, 32'd7,
                               32'h8000_0000, 32'hFFFF_FFF9, 32'h8000_0000, 32'd7};
  logic [W-1:0] d_b  [0:8] = '{32'd5, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd0,
                               32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'hFFFF_FFFE};
  logic [W-1:0] d_hi [0:8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1, 32'd7,
                               32'd0, 32'hFFFF_FFF9, 32'h4000_0000, 32'd1};
  logic [W-1:0] d_lo [0:8] = '{32'hFFFF_FFF1, 32'h0000_0001, 32'hFFFF_FFFD, 32'd3, 32'hFFFF_FFFF,
                               32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFD};

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .opr1(opr1), .opr2(opr2),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic void ref_model(input logic [1:0] f_op, input logic [W-1:0] a, b,
                                    output logic [W-1:0] r_hi, output logic [W-1:0] r_lo);
    longint sp;
    logic [63:0] up;
    int sa, sb;
    sa = a;
    sb = b;
    r_hi = '0;
    r_lo = '0;
    case (f_op)
      2'b00: begin sp = longint'(sa) * longint'(sb); {r_hi, r_lo} = sp; end
      2'b01: begin up = {32'b0, a} * {32'b0, b}; {r_hi, r_lo} = up; end
      default: begin
        if (b == 0) begin r_lo = '1; r_hi = a; end
        else if (f_op == 2'b11) begin r_lo = a / b; r_hi = a % b; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r_lo = a; r_hi = '0; end
        else begin r_lo = sa / sb; r_hi = sa % sb; end
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] f_op);
`ifdef MDU_FAST_MUL_EN
    return f_op[1] ? 34 : 2;
`else
    return 34;
`endif
  endfunction

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return W'($urandom_range(0, 20));
      4: return -W'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Launches one op from the current (post-edge) time and waits for done.
  task automatic run_op(input logic [1:0] t_op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic t_wr_hi, input logic [W-1:0] t_wdata, input int inj_k,
                        output int done_k, output int busy_bad, output logic [W-1:0] hi_k1);
    op = t_op; opr1 = a; opr2 = b; start = 1'b1; wr_hi = t_wr_hi; wdata = t_wdata;
    @(posedge clk); #1;
    start = 1'b0; wr_hi = 1'b0; opr1 = $urandom; opr2 = $urandom;
    done_k = -1; busy_bad = 0; hi_k1 = hi;
    for (int k = 1; k <= 60; k++) begin
      if (done === 1'b1) begin
        done_k = k;
        if (busy !== 1'b0) busy_bad++;
        break;
      end
      if (busy !== 1'b1) busy_bad++;
      if (k == inj_k) begin
        start = 1'b1; op = ~t_op; opr1 = $urandom; opr2 = $urandom;
        wr_hi = 1'b1; wr_lo = 1'b1; wdata = $urandom;
      end
      @(posedge clk); #1;
      start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    op = '0; opr1 = '0; opr2 = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (hi !== '0) begin n_err++; $display("FAIL reset_hi got %h want 0", hi); end
    n_cmp++; if (lo !== '0) begin n_err++; $display("FAIL reset_lo got %h want 0", lo); end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    int dk, bb;
    logic [W-1:0] h1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      run_op(d_op[i], d_a[i], d_b[i], 1'b0, '0, 0, dk, bb, h1);
      n_cmp++; if (dk != exp_lat(d_op[i])) begin n_err++; $display("FAIL dir%0d_latency got %0d want %0d", i, dk, exp_lat(d_op[i])); end
      n_cmp++; if (bb != 0) begin n_err++; $display("FAIL dir%0d_busy got %0d bad cycles want 0", i, bb); end
      n_cmp++; if (hi !== d_hi[i]) begin n_err++; $display("FAIL dir%0d_hi got %h want %h", i, hi, d_hi[i]); end
      n_cmp++; if (lo !== d_lo[i]) begin n_err++; $display("FAIL dir%0d_lo got %h want %h", i, lo, d_lo[i]); end
    end
  endtask

  task automatic test_random();
    int dk, bb;
    logic [W-1:0] h1, eh, el, a, b;
    logic [1:0] o;
    for (int i = 0; i < 20; i++) begin
      o = 2'($urandom_range(0, 3)); a = pick_val(); b = pick_val();
      ref_model(o, a, b, eh, el);
      @(posedge clk); #1;
      run_op(o, a, b, 1'b0, '0, 0, dk, bb, h1);
      n_cmp++; if (dk != exp_lat(o)) begin n_err++; $display("FAIL rnd%0d_latency got %0d want %0d", i, dk, exp_lat(o)); end
      n_cmp++; if (bb != 0) begin n_err++; $display("FAIL rnd%0d_busy got %0d bad cycles want 0", i, bb); end
      n_cmp++; if (hi !== eh) begin n_err++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h got %h want %h", i, o, a, b, hi, eh); end
      n_cmp++; if (lo !== el) begin n_err++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h got %h want %h", i, o, a, b, lo, el); end
    end
  endtask

  task automatic test_back_to_back();
    int dk, bb;
    logic [W-1:0] h1, eh, el, a, b;
    logic [1:0] o;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      o = 2'($urandom_range(0, 3)); a = pick_val(); b = pick_val();
      ref_model(o, a, b, eh, el);
      run_op(o, a, b, 1'b0, '0, 0, dk, bb, h1);
      n_cmp++; if (dk != exp_lat(o)) begin n_err++; $display("FAIL b2b%0d_latency got %0d want %0d", i, dk, exp_lat(o)); end
      n_cmp++; if (hi !== eh) begin n_err++; $display("FAIL b2b%0d_hi got %h want %h", i, hi, eh); end
      n_cmp++; if (lo !== el) begin n_err++; $display("FAIL b2b%0d_lo got %h want %h", i, lo, el); end
    end
  endtask

  task automatic test_ignore_while_busy();
    int dk, bb;
    logic [W-1:0] h1, eh, el, prev_hi;
    ref_model(2'b10, -32'd100, 32'd7, eh, el);
    @(posedge clk); #1;
    run_op(2'b10, -32'd100, 32'd7, 1'b0, '0, 10, dk, bb, h1);
    n_cmp++; if (dk != 34) begin n_err++; $display("FAIL inj_latency got %0d want 34", dk); end
    n_cmp++; if (bb != 0) begin n_err++; $display("FAIL inj_busy got %0d bad cycles want 0", bb); end
    n_cmp++; if (hi !== eh) begin n_err++; $display("FAIL inj_hi got %h want %h", hi, eh); end
    n_cmp++; if (lo !== el) begin n_err++; $display("FAIL inj_lo got %h want %h", lo, el); end
    @(posedge clk); #1;
    prev_hi = hi;
    wr_lo = 1'b1; wdata = 32'h1234;
    @(posedge clk); #1;
    wr_lo = 1'b0;
    n_cmp++; if (lo !== 32'h1234) begin n_err++; $display("FAIL mtlo_lo got %h want 00001234", lo); end
    n_cmp++; if (hi !== prev_hi) begin n_err++; $display("FAIL mtlo_hi got %h want %h", hi, prev_hi); end
    wr_hi = 1'b1; wdata = 32'hCAFE_0001;
    @(posedge clk); #1;
    wr_hi = 1'b0;
    n_cmp++; if (hi !== 32'hCAFE_0001) begin n_err++; $display("FAIL mthi_hi got %h want cafe0001", hi); end
    ref_model(2'b01, 32'd3, 32'd4, eh, el);
    run_op(2'b01, 32'd3, 32'd4, 1'b1, 32'hDEAD_BEEF, 0, dk, bb, h1);
    n_cmp++; if (h1 !== 32'hCAFE_0001) begin n_err++; $display("FAIL start_wins_hi got %h want cafe0001", h1); end
    n_cmp++; if (dk != exp_lat(2'b01)) begin n_err++; $display("FAIL start_wins_latency got %0d want %0d", dk, exp_lat(2'b01)); end
    n_cmp++; if ({hi, lo} !== {eh, el}) begin n_err++; $display("FAIL start_wins_result got %h_%h want %h_%h", hi, lo, eh, el); end
  endtask

  task automatic test_reset_midop();
    int dk, bb;
    logic [W-1:0] h1, eh, el;
    @(posedge clk); #1;
    op = 2'b11; opr1 = 32'hFFFF_0000; opr2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midrst_done got %b want 0", done); end
    n_cmp++; if (hi !== '0) begin n_err++; $display("FAIL midrst_hi got %h want 0", hi); end
    n_cmp++; if (lo !== '0) begin n_err++; $display("FAIL midrst_lo got %h want 0", lo); end
    @(posedge clk); #1;
    n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL midrst_idle got %b want 00", {busy, done}); end
    ref_model(2'b00, 32'hFFFF_FFF6, 32'd123, eh, el);
    run_op(2'b00, 32'hFFFF_FFF6, 32'd123, 1'b0, '0, 0, dk, bb, h1);
    n_cmp++; if (dk != exp_lat(2'b00)) begin n_err++; $display("FAIL postrst_latency got %0d want %0d", dk, exp_lat(2'b00)); end
    n_cmp++; if (hi !== eh) begin n_err++; $display("FAIL postrst_hi got %h want %h", hi, eh); end
    n_cmp++; if (lo !== el) begin n_err++; $display("FAIL postrst_lo got %h want %h", lo, el); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_ignore_while_busy();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
